// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues single-word reads to a memory with
// one-cycle read latency, and hands each instruction to the decoder over valid/ready.
module instr_fetch #(
  parameter int unsigned           ADDR_W    = 16,
  parameter int unsigned           DATA_W    = 16,
  parameter int unsigned           MEM_DEPTH = 1024,
  parameter logic [ADDR_W-1:0]     RESET_PC  = '0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              enable,
  output logic              MemRead,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(MEM_DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state;

  // Addresses wrap modulo the (power-of-two) memory depth.
  function automatic logic [ADDR_W-1:0] wrap_pc(input logic [ADDR_W-1:0] a);
    return a & PC_MASK;
  endfunction

  assign MemRead  = (state == REQ);
  assign mem_addr = (state == REQ) ? pc : '0;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (branch_taken) pc <= wrap_pc(branch_target);
          state <= enable ? REQ : IDLE;
        end
        REQ: begin
          if (branch_taken) begin
            pc    <= wrap_pc(branch_target);
            state <= REQ;
          end else begin
            state <= WAIT;
          end
        end
        // A redirect here drops the returning word; it is never presented.
        WAIT: begin
          if (branch_taken) begin
            pc    <= wrap_pc(branch_target);
            state <= REQ;
          end else begin
            instr       <= mem_rdata;
            instr_pc    <= pc;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (branch_taken) begin
            pc          <= wrap_pc(branch_target);
            instr_valid <= 1'b0;
            state       <= enable ? REQ : IDLE;
          end else if (instr_ready) begin
            pc          <= wrap_pc(pc + ADDR_W'(1));
            instr_valid <= 1'b0;
            state       <= enable ? REQ : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a behavioural 1024x16 memory (registered read).
module tb_instr_fetch;

  logic        CLK;
  logic        reset;
  logic        enable;
  logic        MemRead;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [15:0] pc;

  logic [15:0] mem [0:1023];
  int n_checks;
  int n_fail;

  instr_fetch dut (
    .CLK(CLK), .reset(reset), .enable(enable),
    .MemRead(MemRead), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc(pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (MemRead) mem_rdata <= mem[mem_addr[9:0]];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Entered just after the edge that put the FSM in REQ; leaves it in HOLD.
  task automatic expect_fetch(input string tag, input logic [15:0] addr);
    check({tag, ".memread"}, MemRead, 1'b1);
    check({tag, ".addr"}, mem_addr, addr);
    tick();
    check({tag, ".wait_memread"}, MemRead, 1'b0);
    check({tag, ".wait_valid"}, instr_valid, 1'b0);
    tick();
    check({tag, ".valid"}, instr_valid, 1'b1);
    check({tag, ".instr"}, instr, mem[addr[9:0]]);
    check({tag, ".instr_pc"}, instr_pc, addr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".memread"}, MemRead, 1'b0);
    check({tag, ".addr"}, mem_addr, 16'h0000);
    check({tag, ".instr"}, instr, 16'h0000);
    check({tag, ".instr_pc"}, instr_pc, 16'h0000);
    check({tag, ".valid"}, instr_valid, 1'b0);
    check({tag, ".pc"}, pc, 16'h0000);
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    mem[0] = 16'h27E7;
    mem[1] = 16'h1234;
    mem_rdata = 16'h0000;
    reset = 1'b1;
    enable = 1'b0;
    instr_ready = 1'b0;
    branch_taken = 1'b0;
    branch_target = 16'h0000;
    tick();
    tick();
    check_reset_outputs("rst");
    reset = 1'b0;
    enable = 1'b1;
    instr_ready = 1'b1;

    // Basic back-to-back fetch with ready high.
    tick();
    expect_fetch("t1.f0", 16'h0000);
    check("t1.f0_instr_lit", instr, 16'h27E7);
    tick();
    check("t1.pc_inc", pc, 16'h0001);
    expect_fetch("t1.f1", 16'h0001);
    check("t1.f1_instr_lit", instr, 16'h1234);

    // Decoder stall in HOLD.
    instr_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t2.valid", instr_valid, 1'b1);
      check("t2.instr", instr, 16'h1234);
      check("t2.instr_pc", instr_pc, 16'h0001);
      check("t2.memread", MemRead, 1'b0);
      check("t2.pc", pc, 16'h0001);
    end
    instr_ready = 1'b1;
    tick();
    expect_fetch("t2.f2", 16'h0002);

    // Branch to the last word, then wrap; out-of-range target is masked.
    branch_taken = 1'b1;
    branch_target = 16'h03FF;
    tick();
    branch_taken = 1'b0;
    check("t3.pc_br", pc, 16'h03FF);
    expect_fetch("t3.f3ff", 16'h03FF);
    tick();
    check("t3.pc_wrap", pc, 16'h0000);
    expect_fetch("t3.fwrap", 16'h0000);
    branch_taken = 1'b1;
    branch_target = 16'h0410;
    tick();
    branch_taken = 1'b0;
    check("t3.pc_mask", pc, 16'h0010);
    expect_fetch("t3.f10", 16'h0010);

    // Redirect during WAIT squashes the read from address 5.
    branch_taken = 1'b1;
    branch_target = 16'h0005;
    tick();
    branch_taken = 1'b0;
    check("t4.memread5", MemRead, 1'b1);
    check("t4.addr5", mem_addr, 16'h0005);
    tick();
    branch_taken = 1'b1;
    branch_target = 16'h0010;
    tick();
    branch_taken = 1'b0;
    check("t4.no_valid", instr_valid, 1'b0);
    expect_fetch("t4.f10", 16'h0010);

    // Branch and ready together in HOLD: target wins over pc+1.
    branch_taken = 1'b1;
    branch_target = 16'h0020;
    tick();
    branch_taken = 1'b0;
    check("t5.valid_drop", instr_valid, 1'b0);
    expect_fetch("t5.f20", 16'h0020);

    // Enable low: consume then idle; mid-fetch drop still delivers.
    enable = 1'b0;
    tick();
    check("en.idle_memread", MemRead, 1'b0);
    check("en.idle_pc", pc, 16'h0021);
    tick();
    check("en.idle_stay", MemRead, 1'b0);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    expect_fetch("en.f21", 16'h0021);
    tick();
    check("en.back_idle", MemRead, 1'b0);
    check("en.pc22", pc, 16'h0022);

    // Branch while idle only moves the PC.
    branch_taken = 1'b1;
    branch_target = 16'h0040;
    tick();
    branch_taken = 1'b0;
    check("idle_br.pc", pc, 16'h0040);
    check("idle_br.memread", MemRead, 1'b0);

    // Asynchronous reset between edges during WAIT.
    enable = 1'b1;
    tick();
    check("t6.addr40", mem_addr, 16'h0040);
    tick();
    check("t6.in_wait", MemRead, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("t6.async");
    tick();
    reset = 1'b0;
    tick();
    expect_fetch("t6.refetch", 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
